// File: rtl/matmul.sv
// Pipelined signed matrix multiplier C = A x B: one product register stage followed by a registered adder tree.
// Optional macro MATMUL_OUT_REG_EN adds one extra output register stage (latency LATENCY+1).
module matmul #(
  parameter  int R1      = 2,
  parameter  int C1      = 2,
  parameter  int R2      = 2,
  parameter  int C2      = 2,
  parameter  int W_A     = 8,
  parameter  int W_B     = 8,
  localparam int W_C     = W_A + W_B + $clog2(C1),
  localparam int LATENCY = $clog2(C1) + 1
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    cen,
  input  logic [R1*C1*W_A-1:0]    A,
  input  logic [R2*C2*W_B-1:0]    B,
  output logic [R1*C2*W_C-1:0]    C
);

  // Operand count at tree level l (level 0 is the product row).
  function automatic int lvl_cnt(input int l);
    return (C1 + (1 << l) - 1) >> l;
  endfunction

  function automatic int lvl_off(input int l);
    int s;
    s = 0;
    for (int i = 0; i < l; i++) s += lvl_cnt(i);
    return s;
  endfunction

  localparam int LVLS = $clog2(C1);
  localparam int NO   = R1 * C2;
  localparam int NTOT = lvl_off(LVLS + 1);

  generate
    if (R2 != C1) begin : g_dim_check
      $error("matmul: R2 must equal C1");
    end
  endgenerate

  logic signed [W_C-1:0] w_prod [NO][C1];
  logic signed [W_C-1:0] w_next [NO][NTOT];
  logic signed [W_C-1:0] r_node [NO][NTOT];
  logic signed [W_C-1:0] w_res  [NO];

  always_comb begin
    for (int i = 0; i < R1; i++) begin
      for (int j = 0; j < C2; j++) begin
        for (int k = 0; k < C1; k++) begin
          w_prod[i*C2+j][k] = W_C'($signed(A[(i*C1+k)*W_A +: W_A]))
                            * W_C'($signed(B[(k*C2+j)*W_B +: W_B]));
        end
      end
    end
  end

  // Every node of every tree is one register; odd leftovers are copied up a level unchanged.
  always_comb begin
    for (int o = 0; o < NO; o++) begin
      for (int n = 0; n < NTOT; n++) w_next[o][n] = '0;
      for (int k = 0; k < C1; k++) w_next[o][k] = w_prod[o][k];
      for (int l = 1; l <= LVLS; l++) begin
        for (int k = 0; k < lvl_cnt(l); k++) begin
          if (2*k + 1 < lvl_cnt(l-1))
            w_next[o][lvl_off(l)+k] = r_node[o][lvl_off(l-1)+2*k]
                                    + r_node[o][lvl_off(l-1)+2*k+1];
          else
            w_next[o][lvl_off(l)+k] = r_node[o][lvl_off(l-1)+2*k];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int o = 0; o < NO; o++)
        for (int n = 0; n < NTOT; n++)
          r_node[o][n] <= '0;
    end else if (cen) begin
      r_node <= w_next;
    end
  end

`ifdef MATMUL_OUT_REG_EN
  logic signed [W_C-1:0] r_out [NO];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int o = 0; o < NO; o++) r_out[o] <= '0;
    end else if (cen) begin
      for (int o = 0; o < NO; o++) r_out[o] <= r_node[o][NTOT-1];
    end
  end

  always_comb begin
    for (int o = 0; o < NO; o++) w_res[o] = r_out[o];
  end
`else
  always_comb begin
    for (int o = 0; o < NO; o++) w_res[o] = r_node[o][NTOT-1];
  end
`endif

  genvar gi;
  generate
    for (gi = 0; gi < NO; gi++) begin : g_out
      assign C[gi*W_C +: W_C] = w_res[gi];
    end
  endgenerate

endmodule

// File: tb/tb_matmul.sv
// Randomized self-checking bench for matmul against a queue-based matrix-product reference model.
module tb_matmul;
  localparam int R1  = 2;
  localparam int C1  = 2;
  localparam int R2  = 2;
  localparam int C2  = 2;
  localparam int W_A = 8;
  localparam int W_B = 8;
  localparam int W_C = W_A + W_B + $clog2(C1);
`ifdef MATMUL_OUT_REG_EN
  localparam int LAT = $clog2(C1) + 2;
`else
  localparam int LAT = $clog2(C1) + 1;
`endif
  localparam int NA = R1*C1*W_A;
  localparam int NB = R2*C2*W_B;
  localparam int NC = R1*C2*W_C;

  logic          clk  = 1'b0;
  logic          rstn = 1'b0;
  logic          cen  = 1'b0;
  logic [NA-1:0] a_in = '0;
  logic [NB-1:0] b_in = '0;
  logic [NC-1:0] c_out;

  matmul #(.R1(R1), .C1(C1), .R2(R2), .C2(C2), .W_A(W_A), .W_B(W_B)) dut (
    .clk  (clk),
    .rstn (rstn),
    .cen  (cen),
    .A    (a_in),
    .B    (b_in),
    .C    (c_out)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  logic [NC-1:0] exp_q [$];

  // Plain row-by-column dot products in wide integer arithmetic.
  function automatic logic [NC-1:0] ref_mm(input logic [NA-1:0] a, input logic [NB-1:0] b);
    logic [NC-1:0] r;
    longint s;
    r = '0;
    for (int i = 0; i < R1; i++) begin
      for (int j = 0; j < C2; j++) begin
        s = 0;
        for (int k = 0; k < C1; k++)
          s += longint'($signed(a[(i*C1+k)*W_A +: W_A])) * longint'($signed(b[(k*C2+j)*W_B +: W_B]));
        r[(i*C2+j)*W_C +: W_C] = s[W_C-1:0];
      end
    end
    return r;
  endfunction

  function automatic logic [127:0] pk(input int w, input int v0, input int v1, input int v2, input int v3);
    logic [127:0] r;
    int v [4];
    r = '0;
    v[0] = v0; v[1] = v1; v[2] = v2; v[3] = v3;
    for (int n = 0; n < 4; n++)
      for (int bi = 0; bi < w; bi++)
        r[n*w+bi] = v[n][bi];
    return r;
  endfunction

  task automatic check(input string tag, input logic [NC-1:0] got, input logic [NC-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One clock edge; enabled edges taken out of reset push the reference result of the sampled inputs.
  task automatic step(input logic en, input string tag);
    logic [NC-1:0] exp;
    cen = en;
    @(posedge clk);
    if (en && rstn) exp_q.push_back(ref_mm(a_in, b_in));
    #1;
    exp = (exp_q.size() >= LAT) ? exp_q[exp_q.size()-LAT] : '0;
    check(tag, c_out, exp);
    $display("%0t %s cen=%0b rstn=%0b A=%h B=%h C=%h", $time, tag, en, rstn, a_in, b_in, c_out);
  endtask

  task automatic rand_in();
    a_in = NA'({$urandom, $urandom});
    b_in = NB'({$urandom, $urandom});
  endtask

  initial begin
    #12;
    check("reset_state", c_out, '0);
    step(1'b1, "reset_hold");
    #2 rstn = 1'b1;

    a_in = NA'(pk(W_A, 1, 2, 3, 4));
    b_in = NB'(pk(W_B, 5, 6, 7, 8));
    repeat (LAT) step(1'b1, "basic");
    check("basic_const", c_out, NC'(pk(W_C, 19, 22, 43, 50)));

    a_in = NA'(pk(W_A, -128, -128, -128, -128));
    b_in = NB'(pk(W_B, -128, -128, -128, -128));
    repeat (LAT) step(1'b1, "ext_neg");
    check("ext_neg_const", c_out, NC'(pk(W_C, 32768, 32768, 32768, 32768)));
    b_in = NB'(pk(W_B, 127, 127, 127, 127));
    repeat (LAT) step(1'b1, "ext_mix");
    check("ext_mix_const", c_out, NC'(pk(W_C, -32512, -32512, -32512, -32512)));

    for (int n = 0; n < 100; n++) begin
      rand_in();
      step(1'b1, "stream");
    end

    a_in = NA'(pk(W_A, 1, 2, 3, 4));
    b_in = NB'(pk(W_B, 1, 0, 0, 1));
    step(1'b1, "stall_load");
    for (int n = 0; n < 5; n++) begin
      rand_in();
      step(1'b0, "stall");
    end
    repeat (LAT-1) begin
      rand_in();
      step(1'b1, "resume");
    end
    check("stall_const", c_out, NC'(pk(W_C, 1, 2, 3, 4)));

    for (int n = 0; n < 60; n++) begin
      rand_in();
      step(1'($urandom_range(0, 1)), "rand_cen");
    end

    for (int n = 0; n < 5; n++) begin
      rand_in();
      step(1'b1, "pre_rst");
    end
    #3 rstn = 1'b0;
    #1 check("rst_async", c_out, '0);
    exp_q.delete();
    rand_in();
    step(1'b1, "rst_hold");
    #2 rstn = 1'b1;
    for (int n = 0; n < 20; n++) begin
      rand_in();
      step(1'($urandom_range(0, 1)), "post_rst");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
